// File: rtl/regwrite_scoreboard_pkg.sv
// Shared defaults for the register-write scoreboard: geometry, the opcode
// write mask and the opcode classes that make up that mask.
package regwrite_scoreboard_pkg;

    localparam int DEF_OPW   = 5;
    localparam int DEF_NREG  = 8;
    localparam int DEF_CNT_W = 2;

    localparam logic [31:0] DEF_REGWR_MASK = 32'hFFFE_0FC0;

    // Opcode classes; ALU (6..11) and load (17..31) are the register writers.
    localparam logic [4:0] OPC_NOP       = 5'd0;
    localparam logic [4:0] OPC_ALU_FIRST = 5'd6;
    localparam logic [4:0] OPC_ALU_LAST  = 5'd11;
    localparam logic [4:0] OPC_LD_FIRST  = 5'd17;
    localparam logic [4:0] OPC_LD_LAST   = 5'd31;

endpackage

// File: rtl/regwrite_scoreboard_if.sv
// Issue and writeback bus between the decode stage (master) and the
// register-write scoreboard (slave).
interface regwrite_scoreboard_if #(
    parameter int OPW = 5,
    parameter int RAW = 3
);
    logic           issue_valid;
    logic [OPW-1:0] issue_opcode;
    logic [RAW-1:0] issue_rd;
    logic [RAW-1:0] issue_rs;
    logic [RAW-1:0] issue_rt;
    logic           issue_rs_vld;
    logic           issue_rt_vld;
    logic           issue_ready;
    logic           issue_regwrite;
    logic           wb_valid;
    logic [RAW-1:0] wb_rd;

    modport master (
        output issue_valid, issue_opcode, issue_rd, issue_rs, issue_rt,
               issue_rs_vld, issue_rt_vld, wb_valid, wb_rd,
        input  issue_ready, issue_regwrite
    );

    modport slave (
        input  issue_valid, issue_opcode, issue_rd, issue_rs, issue_rt,
               issue_rs_vld, issue_rt_vld, wb_valid, wb_rd,
        output issue_ready, issue_regwrite
    );
endinterface

// File: rtl/regwrite_scoreboard_decode.sv
// Opcode -> "writes a register" lookup into the parametrised mask.
// Latency: combinational. Backpressure: none.
module regwrite_decode #(
    parameter int                    OPW  = 5,
    parameter logic [(1<<OPW)-1:0]   MASK = '0
) (
    input  logic [OPW-1:0] i_opcode,
    output logic           o_regwrite
);
    assign o_regwrite = MASK[i_opcode];
endmodule

// File: rtl/regwrite_scoreboard.sv
// Per-register pending-write counters gating issue on RAW and counter-full hazards.
// Latency: counters update on the edge after issue/writeback; ready is combinational from registered counts.
// Backpressure: issue_ready drops on source hazard, destination counter at max, or flush.
module regwrite_scoreboard
    import regwrite_scoreboard_pkg::*;
#(
    parameter int                    OPW        = DEF_OPW,
    parameter int                    NREG       = DEF_NREG,
    parameter int                    CNT_W      = DEF_CNT_W,
    localparam int                   MASK_W     = 1 << OPW,
    parameter logic [MASK_W-1:0]     REGWR_MASK = MASK_W'(DEF_REGWR_MASK)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regwrite_scoreboard_if.slave   sb_if,
    input  logic                   flush,
    output logic                   busy,
    output logic                   underflow_err
);
    localparam int               RAW     = $clog2(NREG);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_pend [NREG];
    logic [CNT_W-1:0] w_pend_nxt [NREG];
    logic             r_uflow;

    logic             w_regwrite;
    logic             w_rs_haz;
    logic             w_rt_haz;
    logic             w_rd_full;
    logic             w_ready;
    logic             w_inc;
    logic             w_wb_zero;
    logic [NREG-1:0]  w_inc_vec;
    logic [NREG-1:0]  w_dec_vec;
    logic             w_busy;

    regwrite_decode #(
        .OPW  (OPW),
        .MASK (REGWR_MASK)
    ) u_decode (
        .i_opcode   (sb_if.issue_opcode),
        .o_regwrite (w_regwrite)
    );

    // Ready looks only at registered counts; a writeback this cycle frees the
    // hazard one cycle later, never combinationally.
    assign w_rs_haz  = sb_if.issue_rs_vld && (r_pend[sb_if.issue_rs] != '0);
    assign w_rt_haz  = sb_if.issue_rt_vld && (r_pend[sb_if.issue_rt] != '0);
    assign w_rd_full = w_regwrite && (r_pend[sb_if.issue_rd] == CNT_MAX);
    assign w_ready   = !flush && !w_rs_haz && !w_rt_haz && !w_rd_full;

    assign w_inc     = sb_if.issue_valid && w_ready && w_regwrite;
    assign w_wb_zero = r_pend[sb_if.wb_rd] == '0;

    assign sb_if.issue_ready    = w_ready;
    assign sb_if.issue_regwrite = w_regwrite;

    always_comb begin
        w_inc_vec = '0;
        w_dec_vec = '0;
        w_busy    = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            w_pend_nxt[i] = r_pend[i];
            w_inc_vec[i]  = w_inc && (sb_if.issue_rd == RAW'(i));
            w_dec_vec[i]  = sb_if.wb_valid && !w_wb_zero && (sb_if.wb_rd == RAW'(i));
            w_busy        = w_busy | (r_pend[i] != '0);
            // Increment and decrement on the same register cancel out.
            if (flush)
                w_pend_nxt[i] = '0;
            else if (w_inc_vec[i] && !w_dec_vec[i])
                w_pend_nxt[i] = r_pend[i] + CNT_W'(1);
            else if (w_dec_vec[i] && !w_inc_vec[i])
                w_pend_nxt[i] = r_pend[i] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                r_pend[i] <= '0;
            r_uflow <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++)
                r_pend[i] <= w_pend_nxt[i];
            if (!flush && sb_if.wb_valid && w_wb_zero)
                r_uflow <= 1'b1;
        end
    end

    assign busy          = w_busy;
    assign underflow_err = r_uflow;

endmodule

// File: tb/tb_regwrite_scoreboard.sv
// Scoreboard bench: a driver issues directed then random traffic and queues the
// expected outputs from an array-of-counts model; a negedge monitor checks them.
module tb_regwrite_scoreboard;

    typedef struct {
        bit ready;
        bit regwrite;
        bit busy;
        bit uerr;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;
    logic underflow_err;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          pend_m[8];
    bit          uerr_m = 1'b0;
    logic [31:0] mask_m = 32'hFFFE_0FC0;

    always #5 clk = ~clk;

    regwrite_scoreboard_if #(.OPW(5), .RAW(3)) bus ();

    regwrite_scoreboard dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sb_if         (bus),
        .flush         (flush),
        .busy          (busy),
        .underflow_err (underflow_err)
    );

    task automatic chk(input string nm, input int c, input logic act, input bit req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b, expected %b", nm, c, act, req);
        end
    endtask

    // One cycle of stimulus; the model advances to the state after the next edge.
    task automatic step(input bit v, input int opc, input int rd, input int rs, input int rt,
                        input bit rsv, input bit rtv, input bit wbv, input int wbrd,
                        input bit fl, input bit rst = 1'b1);
        exp_t e;
        bit   rw, rdy, any;
        @(posedge clk);
        #1;
        rst_n              = rst;
        bus.issue_valid    = v;
        bus.issue_opcode   = opc[4:0];
        bus.issue_rd       = rd[2:0];
        bus.issue_rs       = rs[2:0];
        bus.issue_rt       = rt[2:0];
        bus.issue_rs_vld   = rsv;
        bus.issue_rt_vld   = rtv;
        bus.wb_valid       = wbv;
        bus.wb_rd          = wbrd[2:0];
        flush              = fl;
        if (!rst) begin
            foreach (pend_m[i]) pend_m[i] = 0;
            uerr_m = 1'b0;
        end
        rw  = mask_m[opc];
        rdy = !fl && !(rsv && pend_m[rs] != 0) && !(rtv && pend_m[rt] != 0)
                  && !(rw && pend_m[rd] == 3);
        any = 1'b0;
        foreach (pend_m[i]) any |= (pend_m[i] != 0);
        e = '{ready: rdy, regwrite: rw, busy: any, uerr: uerr_m, cyc: cyc};
        q.push_back(e);
        if (fl) begin
            foreach (pend_m[i]) pend_m[i] = 0;
        end else if (rst) begin
            if (wbv) begin
                if (pend_m[wbrd] > 0) pend_m[wbrd]--;
                else uerr_m = 1'b1;
            end
            if (v && rdy && rw) pend_m[rd]++;
        end
        cyc++;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int rd);
        step(1, 8, rd, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("issue_ready",    e.cyc, bus.issue_ready,    e.ready);
                chk("issue_regwrite", e.cyc, bus.issue_regwrite, e.regwrite);
                chk("busy",           e.cyc, busy,               e.busy);
                chk("underflow_err",  e.cyc, underflow_err,      e.uerr);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int wbrd, off;
        bus.issue_valid = 0; bus.issue_opcode = 0; bus.issue_rd = 0; bus.issue_rs = 0;
        bus.issue_rt = 0; bus.issue_rs_vld = 0; bus.issue_rt_vld = 0;
        bus.wb_valid = 0; bus.wb_rd = 0;
        foreach (pend_m[i]) pend_m[i] = 0;

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // RAW hazard on r3 held until one cycle after its writeback
        step(1, 8, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 3, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 3, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 3, 0, 1, 0, 1, 3, 0);
        step(1, 0, 0, 3, 0, 1, 0, 0, 0, 0);
        idle();

        // non-writing opcode leaves counters untouched
        step(1, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 2, 2, 0, 1, 0, 0, 0, 0);

        // counter saturation on r5 and release by writeback
        wr(5); wr(5); wr(5);
        step(1, 8, 5, 0, 0, 0, 0, 1, 5, 0);
        wr(5);
        step(0, 8, 5, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
        idle();

        // same-register inc/dec cancel, then sticky underflow across flush
        wr(1);
        step(1, 8, 1, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0, 1, 0, 1, 4, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // increment with underflow on the same register
        step(1, 20, 6, 0, 0, 0, 0, 1, 6, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // flush overrides a simultaneous valid issue
        wr(0); wr(0); wr(6);
        step(1, 8, 6, 0, 0, 0, 0, 0, 0, 1);
        step(0, 8, 6, 6, 0, 1, 0, 0, 0, 0);

        // async reset between edges with r7 pending
        wr(7); wr(7);
        step(1, 8, 7, 7, 0, 1, 0, 0, 0, 0, 0);
        step(1, 8, 7, 7, 0, 1, 0, 0, 0, 0);
        idle();

        for (int n = 0; n < 600; n++) begin
            wbrd = $urandom_range(0, 7);
            if ($urandom_range(0, 7) != 0) begin
                off = $urandom_range(0, 7);
                for (int k = 0; k < 8; k++)
                    if (pend_m[(off + k) % 8] > 0) begin
                        wbrd = (off + k) % 8;
                        break;
                    end
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 31),
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, wbrd,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 79) != 0);
        end

        repeat (3) @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
